mag_window_stats: RTL and testbench

Downstream consumer of the magnitude stage. It accepts one 8-bit magnitude sample per qualified cycle and accumulates a window of 2^WIN_LOG2 samples. At the end of each window it reports the average, maximum and minimum, and updates a hysteresis alarm. Results are read through one 8-bit output selected by a mux.

---
 rtl/mag_pkg.sv | 16 +
 rtl/mag_hyst_cmp.sv | 39 +++
 rtl/mag_window_stats.sv | 150 +++++++++++++++
 tb/tb_mag_window_stats.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mag_pkg.sv
// Shared constants for the magnitude window statistics block: default width,
// output-select encodings and status-byte bit positions.
package mag_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  localparam logic [1:0] SEL_AVG  = 2'd0;
  localparam logic [1:0] SEL_MAX  = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  localparam int unsigned STAT_ALARM = 7;
  localparam int unsigned STAT_VALID = 6;
  localparam int unsigned STAT_CNT_W = 6;

endpackage

// File: rtl/mag_hyst_cmp.sv
// Hysteresis alarm: on each update strobe, set at or above thr_hi, else clear
// below thr_lo, else hold. Set wins when the thresholds overlap.
module mag_hyst_cmp
  import mag_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upd,
  input  logic [DW-1:0] val,
  input  logic [DW-1:0] thr_hi,
  input  logic [DW-1:0] thr_lo,
  output logic          alarm
);

  logic alarm_q;
  logic alarm_nxt;

  always_comb begin
    alarm_nxt = alarm_q;
    if (val >= thr_hi) begin
      alarm_nxt = 1'b1;
    end else if (val < thr_lo) begin
      alarm_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else if (upd) begin
      alarm_q <= alarm_nxt;
    end
  end

  assign alarm = alarm_q;

endmodule

// File: rtl/mag_window_stats.sv
// Window statistics (avg/max/min) over 2^WIN_LOG2 magnitude samples with a
// hysteresis alarm. Define MAG_STATS_PEAKHOLD_EN for a cross-window peak-hold max.
module mag_window_stats
  import mag_pkg::*;
#(
  parameter int unsigned DW       = DW_DEFAULT,
  parameter int unsigned WIN_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          in_valid,
  input  logic [DW-1:0] in_mag,
  input  logic          clear,
  input  logic [DW-1:0] thr_hi,
  input  logic [DW-1:0] thr_lo,
  input  logic [1:0]    sel,
  output logic [DW-1:0] out_data,
  output logic          win_done,
  output logic          alarm
);

  localparam int unsigned SW = DW + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  logic [SW-1:0]       sum_q;
  logic [DW-1:0]       run_max_q;
  logic [DW-1:0]       run_min_q;
  logic [WIN_LOG2-1:0] cnt_q;

  logic [DW-1:0] avg_q;
  logic [DW-1:0] max_q;
  logic [DW-1:0] min_q;
  logic          has_result_q;
  logic          win_done_q;

  logic          accept;
  logic          complete;
  logic          restart;
  logic [SW-1:0] sum_nxt;
  logic [DW-1:0] max_nxt;
  logic [DW-1:0] min_nxt;
  logic [DW-1:0] avg_nxt;
  logic [DW-1:0] status_c;

  // clear takes precedence over a sample presented in the same cycle
  assign accept   = ena && in_valid && !clear;
  assign complete = accept && (cnt_q == CNT_LAST);
  assign restart  = ena && clear;

  // Running values including the current sample; also the completion results
  assign sum_nxt = sum_q + SW'(in_mag);
  assign max_nxt = (in_mag > run_max_q) ? in_mag : run_max_q;
  assign min_nxt = (in_mag < run_min_q) ? in_mag : run_min_q;
  assign avg_nxt = DW'(sum_nxt >> WIN_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      run_max_q <= '0;
      run_min_q <= '1;
      cnt_q     <= '0;
    end else if (restart || complete) begin
      sum_q     <= '0;
      run_max_q <= '0;
      run_min_q <= '1;
      cnt_q     <= '0;
    end else if (accept) begin
      sum_q     <= sum_nxt;
      run_max_q <= max_nxt;
      run_min_q <= min_nxt;
      cnt_q     <= cnt_q + WIN_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q        <= '0;
      min_q        <= '0;
      has_result_q <= 1'b0;
    end else if (complete) begin
      avg_q        <= avg_nxt;
      min_q        <= min_nxt;
      has_result_q <= 1'b1;
    end
  end

`ifdef MAG_STATS_PEAKHOLD_EN
  // Peak-hold across windows; only reset or clear drop it back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (restart) begin
      max_q <= '0;
    end else if (complete && (max_nxt > max_q)) begin
      max_q <= max_nxt;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (complete) begin
      max_q <= max_nxt;
    end
  end
`endif

  // Reloaded every cycle so a pulse never stretches while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_done_q <= 1'b0;
    end else begin
      win_done_q <= complete;
    end
  end

  assign win_done = win_done_q;

  mag_hyst_cmp #(
    .DW(DW)
  ) u_hyst (
    .clk   (clk),
    .rst_n (rst_n),
    .upd   (complete),
    .val   (avg_nxt),
    .thr_hi(thr_hi),
    .thr_lo(thr_lo),
    .alarm (alarm)
  );

  always_comb begin
    status_c                          = '0;
    status_c[STAT_ALARM]              = alarm;
    status_c[STAT_VALID]              = has_result_q;
    status_c[STAT_CNT_W-1:0]          = STAT_CNT_W'(cnt_q);
  end

  always_comb begin
    out_data = '0;
    case (sel)
      SEL_AVG:  out_data = avg_q;
      SEL_MAX:  out_data = max_q;
      SEL_MIN:  out_data = min_q;
      SEL_STAT: out_data = status_c;
      default:  out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mag_window_stats.sv
// Scoreboard bench for mag_window_stats (WIN_LOG2=3): stimulus pushes expected
// window results, a monitor pops and checks them on every win_done pulse.
module tb_mag_window_stats;
  import mag_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_mag = 8'd0;
  logic [7:0] thr_hi = 8'd200;
  logic [7:0] thr_lo = 8'd1;
  logic [1:0] sel = 2'd0;
  wire  [7:0] out_data;
  wire        win_done;
  wire        alarm;

  typedef struct {
    int avg;
    int mx;
    int mn;
    int al;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pushed = 0;
  int peak   = 0;

  mag_window_stats #(
    .DW(8),
    .WIN_LOG2(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .in_valid(in_valid),
    .in_mag  (in_mag),
    .clear   (clear),
    .thr_hi  (thr_hi),
    .thr_lo  (thr_lo),
    .sel     (sel),
    .out_data(out_data),
    .win_done(win_done),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic probe(input logic [1:0] s, output int d);
    sel = s;
    #1;
    d = int'(out_data);
  endtask

  task automatic cyc(input logic e, input logic v, input logic c, input int m);
    ena      = e;
    in_valid = v;
    clear    = c;
    in_mag   = 8'(m);
    @(posedge clk);
    #1;
  endtask

  // Reported max under the selected build (peak-hold or per-window)
  function automatic int exp_max(input int wmax);
`ifdef MAG_STATS_PEAKHOLD_EN
    if (wmax > peak) peak = wmax;
    return peak;
`else
    return wmax;
`endif
  endfunction

  task automatic push_exp(input int avg, input int mx, input int mn, input int al);
    exp_t e;
    e.avg = avg;
    e.mx  = exp_max(mx);
    e.mn  = mn;
    e.al  = al;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic window(input int s[8], input int avg, input int mx, input int mn,
                        input int al);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        chk("win_done_early", int'(win_done), 0);
        push_exp(avg, mx, mn, al);
      end
      cyc(1'b1, 1'b1, 1'b0, s[i]);
    end
    chk("win_done_latency", int'(win_done), 1);
  endtask

  task automatic window_const(input int v, input int al);
    window('{v, v, v, v, v, v, v, v}, v, v, v, al);
  endtask

  // Monitor: every pulse must match exactly one pending expectation
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (rst_n && win_done) begin
        pulses++;
        chk("pending_expect", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          probe(SEL_AVG, d);
          chk("avg", d, e.avg);
          probe(SEL_MAX, d);
          chk("max", d, e.mx);
          probe(SEL_MIN, d);
          chk("min", d, e.mn);
          probe(SEL_STAT, d);
          chk("status", d, e.al * 128 + 64);
          chk("alarm", int'(alarm), e.al);
        end
      end
    end
  end

  initial begin
    int d;
    int s[8];

    // Reset state
    #2;
    for (int i = 0; i < 4; i++) begin
      probe(2'(i), d);
      chk("reset_out", d, 0);
    end
    chk("reset_alarm", int'(alarm), 0);
    chk("reset_win_done", int'(win_done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: basic window stats
    window('{10, 20, 30, 40, 50, 60, 70, 80}, 45, 80, 10, 0);

    // 2: full-scale zero then 255 (sum 2040, no wrap)
    window_const(0, 0);
    window_const(255, 1);

    // 3: clear with a simultaneous sample discards the partial window
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 200);
    probe(SEL_STAT, d);
    chk("stat_cnt5", d, 128 + 64 + 5);
    cyc(1'b1, 1'b1, 1'b1, 200);
    peak = 0;
    chk("clear_no_pulse", int'(win_done), 0);
    probe(SEL_STAT, d);
    chk("stat_after_clear", d, 128 + 64);
    probe(SEL_AVG, d);
    chk("avg_retained", d, 255);
    probe(SEL_MAX, d);
`ifdef MAG_STATS_PEAKHOLD_EN
    chk("max_after_clear", d, 0);
`else
    chk("max_after_clear", d, 255);
`endif
    window_const(4, 1);

    // 4: hysteresis
    thr_hi = 8'd100;
    thr_lo = 8'd50;
    window_const(120, 1);
    window_const(70, 1);
    window_const(40, 0);
    thr_lo = 8'd150;
    window_const(120, 1);

    // 5: gaps from ena=0 / in_valid=0; ena=0 also masks clear
    thr_lo = 8'd50;
    s = '{10, 20, 30, 40, 50, 60, 70, 80};
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(45, 80, 10, 0);
      cyc(1'b1, 1'b1, 1'b0, s[i]);
      if (i == 7) break;
      cyc(1'b0, 1'b1, 1'b0, 99);
      cyc(1'b1, 1'b0, 1'b0, 99);
      if (i == 3) begin
        cyc(1'b0, 1'b1, 1'b1, 99);
        probe(SEL_STAT, d);
        chk("stat_cnt_gaps", d, 128 + 64 + 4);
      end
    end
    chk("gap_win_done", int'(win_done), 1);
    cyc(1'b0, 1'b0, 1'b0, 0);
    chk("pulse_one_cycle_ena0", int'(win_done), 0);

    // 6: reset mid-window
    window_const(120, 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 7);
    cyc(1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    peak  = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      probe(2'(i), d);
      chk("midreset_out", d, 0);
    end
    chk("midreset_alarm", int'(alarm), 0);
    chk("midreset_win_done", int'(win_done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    window('{90, 10, 20, 30, 40, 50, 60, 70}, 46, 90, 10, 0);
    window_const(30, 0);

    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0);
    chk("pulse_count", pulses, pushed);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
